pace_timer_unit: RTL
====================

PACE_TIMER_UNIT -- requirements
Module: pace_timer_unit

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, meaning clk cycles per timer tick (>=2).
REQ-002 SHALL have parameter A_LOAD, default 800, meaning atrial escape interval in ticks (1..2^CNT_W-1).
REQ-003 SHALL have parameter V_LOAD, default 200, meaning AV interval in ticks (1..2^CNT_W-1).
REQ-004 SHALL have parameter BLANK, default 50, meaning post-pace sense blanking in ticks (0 = no blanking).
REQ-005 SHALL have parameter CNT_W, default 12, meaning width of the interval counters.
REQ-006 SHALL have ports: clk in 1, the single clock; rst in 1, asynchronous active-high reset.
REQ-007 SHALL have ports: sa_raw in 1, async atrial sense comparator; sv_raw in 1, async ventricular sense comparator.
REQ-008 SHALL have ports: ta in 1, reload atrial timer; taen in 1, atrial wait-phase enable; tv in 1, reload ventricular timer; tven in 1, ventricular wait-phase enable.
REQ-009 SHALL have ports: pa in 1, atrial pace pulse; pv in 1, ventricular pace pulse.
REQ-010 SHALL have ports: sa out 1, atrial sensed flag; za out 1, atrial timeout; sv out 1, ventricular sensed flag; zv out 1, ventricular timeout.

Function
REQ-011 SHALL synchronise sa_raw and sv_raw through two flops each, then rising-edge detect on the synchronised value (3rd flop).
REQ-012 SHALL run one prescaler 0..TICK_DIV-1; tick = prescaler at TICK_DIV-1 (wraps to 0); prescaler forced to 0 on any cycle with ta or tv high.
REQ-013 SHALL load cnt_a <= A_LOAD and set armed_a on the edge sampling ta=1; ta has priority over taen and tick in the same cycle.
REQ-014 SHALL decrement cnt_a on edges where tick=1, taen=1, ta=0 and cnt_a!=0; cnt_a SHALL hold at 0 (no wrap).
REQ-015 SHALL drive za = armed_a AND (cnt_a==0), decoded from registers only; with taen held high from the cycle after ta, za rises exactly A_LOAD*TICK_DIV cycles after the ta edge.
REQ-016 SHALL apply REQ-013..015 identically to the ventricular channel with tv, tven, V_LOAD, cnt_v, armed_v, zv.
REQ-017 SHALL load blank_cnt <= BLANK on the edge sampling pa=1 or pv=1; decrement on tick while nonzero; blanked = (blank_cnt!=0).
REQ-018 SHALL set sa on an atrial rising edge when taen=1 and blanked=0; sa SHALL hold until the edge sampling ta=1, which clears it (clear wins over set in the same cycle).
REQ-019 SHALL handle sv identically with tven, tv; a sense edge outside its enable window or while blanked SHALL be discarded, not deferred.
REQ-020 SHALL stop decrementing cnt_a when taen falls; value held, za unaffected until next ta.
REQ-021 SHALL treat pa and pv independently of ta/tv; pace while a channel is counting does not alter cnt_a/cnt_v.

Reset
REQ-022 SHALL on rst=1, asynchronously and immediately: prescaler=0, cnt_a=cnt_v=0, armed_a=armed_v=0, blank_cnt=0, sync/edge flops=0, sa=sv=0, za=zv=0.
REQ-023 SHALL keep all outputs 0 after reset release until the respective ta/tv and sense events occur; reset asserted mid-count SHALL abandon the interval with no za/zv pulse.

Verification (TICK_DIV=4, A_LOAD=5, V_LOAD=3, BLANK=2)
REQ-024 SHALL test: ta pulse at cycle 0, taen high cycles 1.. -> za rises exactly cycle 20, stays high until next ta.
REQ-025 SHALL test: tv at cycle 0, tven high, sv_raw rise at cycle 5 -> sv high at cycle 8, zv stays 0; tv at cycle 10 -> sv 0 from cycle 11.
REQ-026 SHALL test: pv pulse at cycle 0, sv_raw rise at cycle 2 with tven high -> sv stays 0 (blanked); rise again at cycle 15 -> sv high 3 cycles later.
REQ-027 SHALL test: sa_raw rises while taen=0 -> sa stays 0 even after taen later rises.
REQ-028 SHALL test: rst asserted at cycle 10 of a running atrial interval, released at cycle 12 -> za never rises, cnt_a=0, all outputs 0 until next ta.
REQ-029 SHALL test: closed loop with the pacemaker controller, no sensing -> pa, pv alternate with period (A_LOAD+V_LOAD)*TICK_DIV + fixed controller overhead, constant every cycle of the loop.

Source files
------------

// File: rtl/pace_timer_unit.sv
// pace_timer_unit: atrial/ventricular escape timers with synchronised sensing and post-pace blanking
module pace_timer_unit #(
    parameter int TICK_DIV = 1000,
    parameter int A_LOAD   = 800,
    parameter int V_LOAD   = 200,
    parameter int BLANK    = 50,
    parameter int CNT_W    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic sa_raw,
    input  logic sv_raw,
    input  logic ta,
    input  logic taen,
    input  logic tv,
    input  logic tven,
    input  logic pa,
    input  logic pv,
    output logic sa,
    output logic za,
    output logic sv,
    output logic zv
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLANK + 2);
    logic [PW-1:0] pre;
    logic [BW-1:0] blank_cnt;
    logic [CNT_W-1:0] cnt_a, cnt_v;
    logic [2:0] sync_a, sync_v;
    logic armed_a, armed_v, tick, blanked, rise_a, rise_v;
    assign tick    = pre == PW'(TICK_DIV - 1);
    assign blanked = blank_cnt != '0;
    // bits [1:0] are the synchroniser, bit 2 holds the previous synchronised level
    assign rise_a  = sync_a[1] & ~sync_a[2];
    assign rise_v  = sync_v[1] & ~sync_v[2];
    assign za      = armed_a & (cnt_a == '0);
    assign zv      = armed_v & (cnt_v == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre       <= '0;
            blank_cnt <= '0;
            cnt_a     <= '0;
            cnt_v     <= '0;
            armed_a   <= 1'b0;
            armed_v   <= 1'b0;
            sync_a    <= '0;
            sync_v    <= '0;
            sa        <= 1'b0;
            sv        <= 1'b0;
        end else begin
            sync_a    <= {sync_a[1:0], sa_raw};
            sync_v    <= {sync_v[1:0], sv_raw};
            pre       <= (ta | tv | tick) ? '0 : pre + 1'b1;
            blank_cnt <= (pa | pv) ? BW'(BLANK) : (tick && blanked) ? blank_cnt - 1'b1 : blank_cnt;
            if (ta) begin
                cnt_a   <= CNT_W'(A_LOAD);
                armed_a <= 1'b1;
            end else if (tick && taen && cnt_a != '0) begin
                cnt_a <= cnt_a - 1'b1;
            end
            if (tv) begin
                cnt_v   <= CNT_W'(V_LOAD);
                armed_v <= 1'b1;
            end else if (tick && tven && cnt_v != '0) begin
                cnt_v <= cnt_v - 1'b1;
            end
            sa <= ta ? 1'b0 : (rise_a && taen && !blanked) ? 1'b1 : sa;
            sv <= tv ? 1'b0 : (rise_v && tven && !blanked) ? 1'b1 : sv;
        end
    end
endmodule
